// File: rtl/point_spawner.sv
// point_spawner: LFSR-driven collectible placement on a grid, pickup detection, saturating scores.
// Define POINT_TIMEOUT_EN to retire uncollected points after TIMEOUT_CYCLES.
module point_spawner #(
   parameter int unsigned NUM_PLAYERS     = 2,
   parameter int unsigned GRID_STEP       = 32,
   parameter int unsigned GRID_COLS       = 31,
   parameter int unsigned GRID_ROWS       = 23,
   parameter int unsigned POINT_SIZE      = 8,
   parameter int unsigned PLAYER_SIZE     = 12,
   parameter int unsigned COOLDOWN_CYCLES = 10000,
   parameter int unsigned WIN_SCORE       = 31,
   parameter logic [15:0] SEED_X          = 16'hACE1,
   parameter logic [15:0] SEED_Y          = 16'h1D2B,
   parameter int unsigned TIMEOUT_CYCLES  = 2000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [10*NUM_PLAYERS-1:0]  player_x,
   input  logic [10*NUM_PLAYERS-1:0]  player_y,
   output logic [9:0]                 cand_x,
   output logic [9:0]                 cand_y,
   input  logic                       cand_blocked,
   output logic [9:0]                 point_x,
   output logic [9:0]                 point_y,
   output logic                       point_valid,
   output logic [5*NUM_PLAYERS-1:0]   scores,
   output logic                       collect_pulse,
   output logic                       game_over,
   output logic [2:0]                 winner
);

   localparam int unsigned CXW = ($clog2(GRID_COLS) > 5) ? $clog2(GRID_COLS) : 5;
   localparam int unsigned CYW = ($clog2(GRID_ROWS) > 5) ? $clog2(GRID_ROWS) : 5;
   localparam logic [CXW:0] COLS_L = (CXW+1)'(GRID_COLS);
   localparam logic [CYW:0] ROWS_L = (CYW+1)'(GRID_ROWS);
   localparam logic [CXW:0] LAST_CX = (CXW+1)'(GRID_COLS - 1);
   localparam logic [CYW:0] LAST_CY = (CYW+1)'(GRID_ROWS - 1);
   localparam logic [15:0] SEED_X_EFF = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;
   localparam logic [15:0] SEED_Y_EFF = (SEED_Y == 16'h0000) ? 16'h0001 : SEED_Y;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic signed [10:0] REACH = 11'(POINT_SIZE + PLAYER_SIZE);
   localparam logic [9:0] POINT_RST = 10'(GRID_STEP);
   localparam logic [4:0] WIN = 5'(WIN_SCORE);
   localparam int unsigned CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] COOL_LOAD = (COOLDOWN_CYCLES == 0) ? '0 : CNT_W'(COOLDOWN_CYCLES - 1);
`ifdef POINT_TIMEOUT_EN
   localparam int unsigned AGE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {SEARCH, ACTIVE, COOLDOWN, DONE} state_t;

   state_t           state;
   logic [15:0]      lfsr_x, lfsr_y;
   logic [CNT_W-1:0] cool_cnt;
`ifdef POINT_TIMEOUT_EN
   logic [AGE_W-1:0] age;
`endif
   logic [CXW-1:0]   cx;
   logic [CYW-1:0]   cy;
   logic             in_range, start_cell, cand_hit, cand_ok;
   logic             pick_hit;
   logic [2:0]       pick_idx;
   logic [4:0]       pick_score;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   // 11-bit signed differences so a player left of / above the point cannot wrap
   function automatic logic overlaps(input logic [9:0] ax, input logic [9:0] ay,
                                     input logic [9:0] bx, input logic [9:0] by);
      logic signed [10:0] dx, dy;
      dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
      dy = $signed({1'b0, ay}) - $signed({1'b0, by});
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      return (dx <= REACH) && (dy <= REACH);
   endfunction

   assign cx = CXW'(lfsr_x[4:0]);
   assign cy = CYW'(lfsr_y[4:0]);

   always_comb begin
      cand_x = 10'(GRID_STEP * (32'(cx) + 32'd1));
      cand_y = 10'(GRID_STEP * (32'(cy) + 32'd1));
   end

   assign in_range   = ({1'b0, cx} < COLS_L) && ({1'b0, cy} < ROWS_L);
   assign start_cell = ((cx == '0) && (cy == '0)) ||
                       (({1'b0, cx} == LAST_CX) && ({1'b0, cy} == LAST_CY));

   always_comb begin
      cand_hit = 1'b0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++)
         if (overlaps(cand_x, cand_y, player_x[10*i +: 10], player_y[10*i +: 10]))
            cand_hit = 1'b1;
   end

   assign cand_ok = in_range && !cand_blocked && !start_cell && !cand_hit;

   // lowest-index overlapping player wins a simultaneous pickup
   always_comb begin
      pick_hit   = 1'b0;
      pick_idx   = '0;
      pick_score = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++)
         if (!pick_hit && overlaps(point_x, point_y, player_x[10*i +: 10], player_y[10*i +: 10])) begin
            pick_hit   = 1'b1;
            pick_idx   = 3'(i);
            pick_score = (scores[5*i +: 5] == 5'd31) ? 5'd31 : scores[5*i +: 5] + 5'd1;
         end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= SEARCH;
         lfsr_x        <= SEED_X_EFF;
         lfsr_y        <= SEED_Y_EFF;
         cool_cnt      <= '0;
         point_x       <= POINT_RST;
         point_y       <= POINT_RST;
         point_valid   <= 1'b0;
         scores        <= '0;
         collect_pulse <= 1'b0;
         game_over     <= 1'b0;
         winner        <= '0;
`ifdef POINT_TIMEOUT_EN
         age           <= '0;
`endif
      end else begin
         lfsr_x        <= lfsr_step(lfsr_x);
         lfsr_y        <= lfsr_step(lfsr_y);
         collect_pulse <= 1'b0;
         unique case (state)
            SEARCH:
               if (cand_ok) begin
                  point_x     <= cand_x;
                  point_y     <= cand_y;
                  point_valid <= 1'b1;
                  state       <= ACTIVE;
`ifdef POINT_TIMEOUT_EN
                  age         <= '0;
`endif
               end
            ACTIVE:
               if (pick_hit) begin
                  scores[5*pick_idx +: 5] <= pick_score;
                  collect_pulse <= 1'b1;
                  point_valid   <= 1'b0;
                  if (pick_score == WIN) begin
                     game_over <= 1'b1;
                     winner    <= pick_idx;
                     state     <= DONE;
                  end else if (COOLDOWN_CYCLES == 0) begin
                     state <= SEARCH;
                  end else begin
                     state    <= COOLDOWN;
                     cool_cnt <= COOL_LOAD;
                  end
               end
`ifdef POINT_TIMEOUT_EN
               else if (age == AGE_LAST) begin
                  point_valid <= 1'b0;
                  state       <= SEARCH;
               end else begin
                  age <= age + AGE_W'(1);
               end
`endif
            COOLDOWN:
               if (cool_cnt == '0) state <= SEARCH;
               else cool_cnt <= cool_cnt - CNT_W'(1);
            DONE: ;
            default: state <= SEARCH;
         endcase
      end
   end

endmodule

// File: tb/tb_point_spawner.sv
// Scoreboard bench for point_spawner: pickups push expected score snapshots, a monitor checks them.
`timescale 1ns/1ps
module tb_point_spawner;
   localparam int unsigned COOL = 4;
   localparam int unsigned TOUT = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] player_x, player_y;
   logic [9:0]  cand_x, cand_y;
   logic        cand_blocked;
   logic [9:0]  point_x, point_y;
   logic        point_valid;
   logic [9:0]  scores;
   logic        collect_pulse, game_over;
   logic [2:0]  winner;

   always #5 clk = ~clk;

   point_spawner #(
      .NUM_PLAYERS(2),
      .COOLDOWN_CYCLES(COOL),
      .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .player_x(player_x), .player_y(player_y),
      .cand_x(cand_x), .cand_y(cand_y), .cand_blocked(cand_blocked),
      .point_x(point_x), .point_y(point_y), .point_valid(point_valid),
      .scores(scores), .collect_pulse(collect_pulse),
      .game_over(game_over), .winner(winner)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 25) $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // reference generator: LFSR taps 16,14,13,11 and the candidate legality rules
   logic [15:0] m_lx, m_ly;
   logic        m_init = 1'b0;
   logic        m_valid;
   logic [9:0]  m_cx, m_cy;

   function automatic logic [15:0] galois(input logic [15:0] s);
      logic fb;
      fb = s[0];
      s  = s >> 1;
      if (fb) s = s ^ 16'b1011_0100_0000_0000;
      return s;
   endfunction

   function automatic logic legal(input logic [15:0] lx, input logic [15:0] ly);
      int cx, cy, x, y, dx, dy;
      cx = int'(lx[4:0]);
      cy = int'(ly[4:0]);
      if (cx > 30 || cy > 22 || cand_blocked) return 1'b0;
      x = 32 * (cx + 1);
      y = 32 * (cy + 1);
      if ((x == 32 && y == 32) || (x == 992 && y == 736)) return 1'b0;
      for (int p = 0; p < 2; p++) begin
         dx = x - int'(player_x[10*p +: 10]);
         dy = y - int'(player_y[10*p +: 10]);
         if (dx < 0) dx = -dx;
         if (dy < 0) dy = -dy;
         if (dx <= 20 && dy <= 20) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_lx    <= 16'hACE1;
         m_ly    <= 16'h1D2B;
         m_valid <= 1'b0;
         m_init  <= 1'b1;
      end else begin
         m_valid <= legal(m_lx, m_ly);
         m_cx    <= 10'(32 * (int'(m_lx[4:0]) + 1));
         m_cy    <= 10'(32 * (int'(m_ly[4:0]) + 1));
         m_lx    <= galois(m_lx);
         m_ly    <= galois(m_ly);
      end
   end

   typedef struct {
      logic [9:0] scores;
      logic       go;
      logic [2:0] win;
   } exp_t;

   exp_t sb[$];
   exp_t got_e;
   logic pv_prev = 1'b0;

   always @(negedge clk) begin
      if (collect_pulse) begin
         check("collect_expected", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check("collect_scores", scores, got_e.scores);
            check("collect_game_over", game_over, got_e.go);
            if (got_e.go) check("collect_winner", winner, got_e.win);
            check("collect_pv_low", point_valid, 0);
         end
      end
      if (point_valid && !pv_prev && !rst) begin
         check("spawn_legal", m_valid, 1);
         check("spawn_point", {point_x, point_y}, {m_cx, m_cy});
      end
      pv_prev = point_valid;
      if (m_init && m_lx[4:0] < 5'd31 && m_ly[4:0] < 5'd23)
         check("cand_xy", {cand_x, cand_y},
               {10'(32 * (int'(m_lx[4:0]) + 1)), 10'(32 * (int'(m_ly[4:0]) + 1))});
   end

   logic [9:0]  home_x[2], home_y[2];
   int unsigned exp_score[2];

   task automatic place_home();
      for (int p = 0; p < 2; p++) begin
         player_x[10*p +: 10] = home_x[p];
         player_y[10*p +: 10] = home_y[p];
      end
   endtask

   // valid from the next edge on only when the reference candidate at that edge is legal
   task automatic await_spawn(input string name);
      bit seen = 0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         if (m_valid) begin
            check(name, point_valid, 1);
            seen = 1;
         end else begin
            check({name, "_hold"}, point_valid, 0);
         end
      end
      if (!seen) check({name, "_timeout"}, point_valid, 1);
   endtask

   task automatic pickup(input logic [1:0] who, input int unsigned block_cycles);
      int unsigned w;
      exp_t e;
      bit got = 0;
      check("pickup_ready", point_valid, 1);
      w = who[0] ? 0 : 1;
      if (exp_score[w] < 31) exp_score[w]++;
      e.scores = {5'(exp_score[1]), 5'(exp_score[0])};
      e.go     = (exp_score[w] == 31);
      e.win    = 3'(w);
      sb.push_back(e);
      for (int p = 0; p < 2; p++)
         if (who[p]) begin
            player_x[10*p +: 10] = point_x;
            player_y[10*p +: 10] = point_y;
         end
      for (int n = 0; n < 8 && !got; n++) begin
         @(negedge clk);
         got = collect_pulse;
      end
      check("pickup_seen", got, 1);
      place_home();
      if (e.go) return;
      if (block_cycles != 0) begin
         int unsigned hi = 0;
         cand_blocked = 1'b1;
         repeat (block_cycles) begin
            @(negedge clk);
            if (point_valid) hi++;
         end
         check("blocked_no_spawn", hi, 0);
         cand_blocked = 1'b0;
      end else begin
         for (int unsigned n = 0; n < COOL; n++) begin
            @(negedge clk);
            check("cooldown_low", point_valid, 0);
         end
      end
      await_spawn("respawn");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n, hi;
      rst          = 1'b1;
      cand_blocked = 1'b0;
      home_x[0] = 10'd32;  home_y[0] = 10'd32;
      home_x[1] = 10'd992; home_y[1] = 10'd736;
      place_home();
      exp_score[0] = 0;
      exp_score[1] = 0;

      repeat (3) begin
         @(negedge clk);
         check("rst_outs", {point_valid, collect_pulse, game_over, winner, scores}, 0);
         check("rst_point", {point_x, point_y}, {10'd32, 10'd32});
      end
      rst = 1'b0;

      // seed cells: cx = 0xE1[4:0] = 1, cy = 0x2B[4:0] = 11 -> (64,384), legal on the first edge
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!point_valid && n < 64);
      check("first_spawn_cycles", n, 1);
      check("first_spawn_xy", {point_x, point_y}, {10'd64, 10'd384});

      pickup(2'b10, 0);
      pickup(2'b11, 500);
      repeat (30) pickup(2'b01, 0);
      check("win_state", {game_over, winner}, {1'b1, 3'd0});
      check("win_scores", scores, {5'd1, 5'd31});

      player_x[9:0] = point_x;
      player_y[9:0] = point_y;
      hi = 0;
      repeat (1000) begin
         @(negedge clk);
         if (point_valid || collect_pulse || !game_over || scores != {5'd1, 5'd31}) hi++;
      end
      check("done_frozen", hi, 0);

      // player 1 parked on the seed cell forces the first candidate to be rejected
      home_x[1] = 10'd70;
      home_y[1] = 10'd390;
      place_home();
      rst = 1'b1;
      @(negedge clk);
      check("rst2_outs", {point_valid, collect_pulse, game_over, winner, scores}, 0);
      check("rst2_point", {point_x, point_y}, {10'd32, 10'd32});
      rst = 1'b0;
      exp_score[0] = 0;
      exp_score[1] = 0;
      @(negedge clk);
      check("overlap_reject", point_valid, 0);
      await_spawn("spawn_after_reject");

`ifdef POINT_TIMEOUT_EN
      n = 0;
      while (point_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", n, TOUT);
      check("timeout_scores", scores, 0);
      await_spawn("spawn_after_timeout");
`else
      repeat (200) @(negedge clk);
      check("point_persists", point_valid, 1);
`endif

      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
